// File: rtl/rfi_power_reader_pkg.sv
// Shared types and defaults for the RFI power-vector capture block.
// Four-state capture FSM encoding plus default geometry of the stored vector.
package rfi_power_reader_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    CAPTURE    = 2'd2,
    READY      = 2'd3
  } state_t;

  localparam int DEF_DIN_WIDTH    = 16;
  localparam int DEF_CHANNEL_ADDR = 9;
  localparam int DEF_RAM_LATENCY  = 2;
  localparam int DEF_CNT_WIDTH    = 16;

endpackage

// File: rtl/rfi_power_reader_bram_sdp.sv
// Simple dual-port RAM, one write and one read port; read data appears LAT clocks after i_rd_en.
// No backpressure: every write and every read request is taken on the cycle it is presented.
module bram_sdp #(
  parameter int DW  = 16,
  parameter int AW  = 9,
  parameter int LAT = 2
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data
);

  logic [DW-1:0] r_mem  [2**AW];
  logic [DW-1:0] r_pipe [LAT];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // The array is sampled on the accepting edge, so later writes never reach a read in flight.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_pipe[0] <= '0;
    end else if (i_rd_en) begin
      r_pipe[0] <= r_mem[i_rd_addr];
    end
  end

  for (genvar g = 1; g < LAT; g++) begin : g_out_reg
    always_ff @(posedge clk) begin
      if (i_rst) begin
        r_pipe[g] <= '0;
      end else begin
        r_pipe[g] <= r_pipe[g-1];
      end
    end
  end

  assign o_rd_data = r_pipe[LAT-1];

endmodule

// File: rtl/rfi_power_reader.sv
// Captures one full detector vector into RAM on arm, then serves host reads while READY.
// Reads return RAM_LATENCY clocks after rd_en; no input backpressure, samples outside capture are dropped.
module rfi_power_reader
  import rfi_power_reader_pkg::*;
#(
  parameter int DIN_WIDTH    = DEF_DIN_WIDTH,
  parameter int CHANNEL_ADDR = DEF_CHANNEL_ADDR,
  parameter int RAM_LATENCY  = DEF_RAM_LATENCY,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DIN_WIDTH-1:0]    din,
  input  logic                    din_valid,
  input  logic                    din_first,
  input  logic                    warning_in,
  input  logic                    arm,
  input  logic [CHANNEL_ADDR-1:0] rd_addr,
  input  logic                    rd_en,
  output logic [DIN_WIDTH-1:0]    rd_data,
  output logic                    rd_valid,
  output logic                    ready,
  output logic                    busy,
  output logic                    frame_warn,
  output logic                    frame_err,
  output logic [CNT_WIDTH-1:0]    frame_cnt
);

  localparam logic [CHANNEL_ADDR-1:0] LAST_ADDR = {CHANNEL_ADDR{1'b1}};

  state_t                  r_state;
  logic [CHANNEL_ADDR-1:0] r_wr_addr;
  logic [RAM_LATENCY-1:0]  r_vld;
  logic                    r_ready;
  logic                    r_busy;
  logic                    r_frame_warn;
  logic                    r_frame_err;
  logic [CNT_WIDTH-1:0]    r_frame_cnt;

  logic                    w_restart;
  logic                    w_wr_en;
  logic [CHANNEL_ADDR-1:0] w_wr_addr;
  logic                    w_rd_acc;

  // A channel-0 marker mid-vector means we lost alignment: restart from that sample.
  assign w_restart = (r_state == CAPTURE) && din_valid && din_first && (r_wr_addr != '0);
  assign w_wr_en   = din_valid && (((r_state == WAIT_FIRST) && din_first) || (r_state == CAPTURE));
  assign w_wr_addr = ((r_state == WAIT_FIRST) || w_restart) ? '0 : r_wr_addr;
  assign w_rd_acc  = rd_en && (r_state == READY);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wr_addr    <= '0;
      r_vld        <= '0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_warn <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_vld <= (r_vld << 1) | RAM_LATENCY'(w_rd_acc);
      case (r_state)
        IDLE: begin
          if (arm) begin
            r_state <= WAIT_FIRST;
            r_busy  <= 1'b1;
          end
        end
        WAIT_FIRST: begin
          if (din_valid && din_first) begin
            r_state      <= CAPTURE;
            r_wr_addr    <= CHANNEL_ADDR'(1);
            r_frame_warn <= 1'b0;
          end
        end
        CAPTURE: begin
          if (w_restart) begin
            r_frame_warn <= warning_in;
          end else if (warning_in) begin
            r_frame_warn <= 1'b1;
          end
          if (w_restart) begin
            r_frame_err <= 1'b1;
            r_wr_addr   <= CHANNEL_ADDR'(1);
          end else if (din_valid) begin
            r_wr_addr <= r_wr_addr + 1'b1;
            if (r_wr_addr == LAST_ADDR) begin
              r_state     <= READY;
              r_busy      <= 1'b0;
              r_ready     <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 1'b1;
            end
          end
        end
        READY: begin
          if (arm) begin
            r_state <= WAIT_FIRST;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  bram_sdp #(
    .DW  (DIN_WIDTH),
    .AW  (CHANNEL_ADDR),
    .LAT (RAM_LATENCY)
  ) u_ram (
    .clk       (clk),
    .i_rst     (rst),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (din),
    .i_rd_en   (w_rd_acc),
    .i_rd_addr (rd_addr),
    .o_rd_data (rd_data)
  );

  assign rd_valid   = r_vld[RAM_LATENCY-1];
  assign ready      = r_ready;
  assign busy       = r_busy;
  assign frame_warn = r_frame_warn;
  assign frame_err  = r_frame_err;
  assign frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_rfi_power_reader.sv
// Bench for rfi_power_reader with an 8-word vector and 2-clock read latency.
// Expected read data is queued when rd_en is driven and matched when rd_valid appears.
module tb_rfi_power_reader;

  localparam int DW  = 16;
  localparam int CA  = 3;
  localparam int LAT = 2;
  localparam int CW  = 16;
  localparam int N   = 8;

  logic          clk;
  logic          rst;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_first;
  logic          warning_in;
  logic          arm;
  logic [CA-1:0] rd_addr;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          ready;
  logic          busy;
  logic          frame_warn;
  logic          frame_err;
  logic [CW-1:0] frame_cnt;

  typedef struct {
    logic [DW-1:0] dat;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  rfi_power_reader #(
    .DIN_WIDTH    (DW),
    .CHANNEL_ADDR (CA),
    .RAM_LATENCY  (LAT),
    .CNT_WIDTH    (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_first  (din_first),
    .warning_in (warning_in),
    .arm        (arm),
    .rd_addr    (rd_addr),
    .rd_en      (rd_en),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .ready      (ready),
    .busy       (busy),
    .frame_warn (frame_warn),
    .frame_err  (frame_err),
    .frame_cnt  (frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (rd_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        check("rd_valid_unexpected", 32'(rd_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", 32'(rd_data), 32'(e.dat));
        check("rd_latency", cyc, e.due);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic first, input logic warn);
    din        = d;
    din_valid  = 1'b1;
    din_first  = first;
    warning_in = warn;
    tick();
    din_valid  = 1'b0;
    din_first  = 1'b0;
    warning_in = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic stream(input logic [DW-1:0] base, input int warn_idx);
    for (int i = 0; i < N; i++) send(DW'(base + i), i == 0, i == warn_idx);
  endtask

  task automatic read_vec(input logic [DW-1:0] base);
    for (int i = 0; i < N; i++) begin
      rd_en   = 1'b1;
      rd_addr = CA'(i);
      sb.push_back(exp_t'{dat: DW'(base + i), due: cyc + LAT});
      tick();
    end
    rd_en = 1'b0;
    repeat (LAT + 1) tick();
    check("read_drain", sb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; din_first = 1'b0; warning_in = 1'b0;
    arm = 1'b0; rd_addr = '0; rd_en = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", 32'(ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_err", 32'(frame_err), 0);
    check("rst_warn", 32'(frame_warn), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);

    // 1: basic capture and readback
    do_arm();
    check("s1_busy", 32'(busy), 1);
    check("s1_ready_pre", 32'(ready), 0);
    stream(16'h0010, -1);
    check("s1_ready", 32'(ready), 1);
    check("s1_busy_done", 32'(busy), 0);
    check("s1_cnt", 32'(frame_cnt), 1);
    read_vec(16'h0010);

    // 2: samples before the channel-0 marker are dropped; arm while waiting is ignored
    do_arm();
    check("s2_ready_drop", 32'(ready), 0);
    arm = 1'b1;
    send(16'h0099, 1'b0, 1'b0);
    arm = 1'b0;
    send(16'h0098, 1'b0, 1'b0);
    send(16'h0097, 1'b0, 1'b0);
    check("s2_busy_wait", 32'(busy), 1);
    stream(16'h0020, -1);
    check("s2_ready", 32'(ready), 1);
    check("s2_cnt", 32'(frame_cnt), 2);
    read_vec(16'h0020);

    // 3: gappy valid
    do_arm();
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) check("s3_ready_early", 32'(ready), 0);
      send(DW'(16'h0010 + i), i == 0, 1'b0);
      tick();
    end
    check("s3_ready", 32'(ready), 1);
    check("s3_cnt", 32'(frame_cnt), 3);
    read_vec(16'h0010);

    // 4: marker at channel 5 restarts the capture
    check("s4_err_pre", 32'(frame_err), 0);
    do_arm();
    for (int i = 0; i < 5; i++) send(DW'(16'h0030 + i), i == 0, 1'b0);
    for (int i = 0; i < N - 1; i++) send(DW'(16'h0040 + i), i == 0, 1'b0);
    check("s4_err", 32'(frame_err), 1);
    check("s4_ready_early", 32'(ready), 0);
    send(16'h0047, 1'b0, 1'b0);
    check("s4_ready", 32'(ready), 1);
    check("s4_cnt", 32'(frame_cnt), 4);
    read_vec(16'h0040);

    // 5: warning on the final write, then reads in flight across arm, then a clean capture
    do_arm();
    stream(16'h0050, 7);
    check("s5_warn", 32'(frame_warn), 1);
    check("s5_cnt", 32'(frame_cnt), 5);
    rd_en = 1'b1; rd_addr = 3'd0;
    sb.push_back(exp_t'{dat: 16'h0050, due: cyc + LAT});
    tick();
    rd_addr = 3'd7; arm = 1'b1;
    sb.push_back(exp_t'{dat: 16'h0057, due: cyc + LAT});
    tick();
    rd_en = 1'b0; arm = 1'b0;
    check("s5_ready_drop", 32'(ready), 0);
    check("s5_warn_hold", 32'(frame_warn), 1);
    stream(16'h0060, -1);
    check("s5_inflight_drain", sb.size(), 0);
    check("s5_warn_clean", 32'(frame_warn), 0);
    check("s5_cnt2", 32'(frame_cnt), 6);
    read_vec(16'h0060);

    // 6: squash in-flight read on reset, reads outside READY, reset mid-capture
    rd_en = 1'b1; rd_addr = 3'd3;
    tick();
    rd_en = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s6_rst_ready", 32'(ready), 0);
    check("s6_rst_busy", 32'(busy), 0);
    check("s6_rst_err", 32'(frame_err), 0);
    check("s6_rst_cnt", 32'(frame_cnt), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s6_squash", 32'(rd_valid), 0);
    end
    rd_en = 1'b1; rd_addr = 3'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("s6_idle_rd", 32'(rd_valid), 0);
    end
    send(16'h0077, 1'b1, 1'b0);
    check("s6_idle_busy", 32'(busy), 0);
    do_arm();
    for (int i = 0; i < 4; i++) begin
      send(DW'(16'h0070 + i), i == 0, 1'b0);
      check("s6_cap_rd", 32'(rd_valid), 0);
    end
    din = 16'h0074; din_valid = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; din_valid = 1'b0; rd_en = 1'b0;
    check("s6_cap_busy", 32'(busy), 0);
    check("s6_cap_ready", 32'(ready), 0);
    check("s6_cap_cnt", 32'(frame_cnt), 0);
    tick();
    check("s6_cap_rd_after", 32'(rd_valid), 0);
    send(16'h0070, 1'b1, 1'b0);
    check("s6_back_idle", 32'(busy), 0);
    do_arm();
    stream(16'h0080, -1);
    check("s6_final_ready", 32'(ready), 1);
    check("s6_final_cnt", 32'(frame_cnt), 1);
    read_vec(16'h0080);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
